add_sub_stage: RTL and testbench

ADD_SUB_STAGE -- requirements
Module: add_sub_stage

---
 rtl/add_sub_stage.sv | 141 ++++++++++++++
 tb/tb_add_sub_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_stage.sv
// Operand stage for an external 32-bit adder with a 2-entry in-order result FIFO.
// Define ADD_SUB_STAGE_CARRY_CHAIN_EN to chain the previous op's carry into ADDC/SUBB.
module add_sub_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_cin,
  input  logic [31:0]      add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ENTRY_W = TAG_W + 36;

  logic             s1_valid_reg;
  logic [1:0]       s1_op_reg;
  logic [31:0]      s1_a_reg;
  logic [31:0]      s1_b_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [ENTRY_W-1:0] entries [2];
  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] head_entry;

  logic pop;
  logic advance;
  logic chain_cin;
  logic overflow;

  assign pop       = out_valid && out_ready;
  assign advance   = s1_valid_reg && ((count_reg < 2'd2) || pop);
  assign in_ready  = !s1_valid_reg || advance;
  assign out_valid = (count_reg != 2'd0);

`ifdef ADD_SUB_STAGE_CARRY_CHAIN_EN
  logic carry_q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q_reg <= 1'b0;
    end else if (advance) begin
      carry_q_reg <= add_cout;
    end
  end

  assign chain_cin = carry_q_reg;
`else
  // Without chaining, ADDC/SUBB fall back to the plain ADD/SUB carry-in.
  assign chain_cin = s1_op_reg[0];
`endif

  // Op encoding: bit 0 selects subtract, bit 1 selects the chained carry-in.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (s1_valid_reg) begin
      add_a   = s1_a_reg;
      add_b   = s1_op_reg[0] ? ~s1_b_reg : s1_b_reg;
      add_cin = s1_op_reg[1] ? chain_cin : s1_op_reg[0];
    end
  end

  assign overflow  = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
  assign new_entry = {s1_tag_reg, add_s[31], (add_s == 32'd0), overflow, add_cout, add_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_tag_reg   <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_op_reg  <= in_op;
        s1_a_reg   <= in_a;
        s1_b_reg   <= in_b;
        s1_tag_reg <= in_tag;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [ENTRY_W-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (advance && (int'(wr_ptr_reg) == gi)) begin
          entry_reg <= new_entry;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (advance) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
      case ({advance, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = entries[rd_ptr_reg];
  assign {out_tag, out_neg, out_zero, out_overflow, out_carry, out_result} =
      out_valid ? head_entry : '0;

endmodule

// File: tb/tb_add_sub_stage.sv
// Self-checking bench for add_sub_stage: models the external adder and keeps a
// scoreboard of expected results in acceptance order.
module tb_add_sub_stage;

  localparam int TAG_W  = 5;
  localparam int N_RAND = 100;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             neg;
    logic             zero;
    logic             ovf;
    logic             carry;
    logic [31:0]      result;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic             out_carry, out_overflow, out_zero, out_neg;
  logic [TAG_W-1:0] out_tag;

  exp_t out_pack;
  exp_t exp_q[$];
  logic model_carry = 1'b0;
  int   checks = 0;
  int   errors = 0;

  add_sub_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_neg(out_neg), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // External combinational adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign out_pack = {out_tag, out_neg, out_zero, out_overflow, out_carry, out_result};

  task automatic push_expected(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag);
    exp_t        e;
    logic [31:0] bop;
    logic        cin;
    logic [32:0] sum;
    longint      sx;
    bop = op[0] ? ~b : b;
`ifdef ADD_SUB_STAGE_CARRY_CHAIN_EN
    cin = op[1] ? model_carry : op[0];
`else
    cin = op[0];
`endif
    sum = {1'b0, a} + {1'b0, bop} + {32'd0, cin};
    sx  = longint'($signed(a)) + longint'($signed(bop)) + longint'(cin);
    e.result = sum[31:0];
    e.carry  = sum[32];
    e.ovf    = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
    e.zero   = (sum[31:0] == 32'd0);
    e.neg    = sum[31];
    e.tag    = tag;
    model_carry = sum[32];
    exp_q.push_back(e);
  endtask

  // Presents one op from a negedge and holds it until accepted (bounded).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, output bit ok);
    int w;
    w = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    while (!in_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    ok = in_ready;
    @(posedge clk);
    if (ok) push_expected(op, a, b, tag);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_pack !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h required 0", out_pack);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== 65'd0) begin
      errors++; $display("FAIL reset_adder got a=%h b=%h cin=%b required 0", add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_add_wrap();
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    issue(2'b00, 32'hFFFF_FFFF, 32'h1, 5'd1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_wrap_accept got=0 required=1"); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_wrap_early out_valid=%b required 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_wrap_latency out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    $display("txn add_wrap tag=%0d result=%h carry=%b", out_tag, out_result, out_carry);
    checks++;
    if (out_pack !== e) begin errors++; $display("FAIL add_wrap_model got=%h required=%h", out_pack, e); end
    checks++;
    if (out_result !== 32'h0 || out_carry !== 1'b1 || out_zero !== 1'b1 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap_flags got r=%h c=%b z=%b v=%b required 0/1/1/0", out_result, out_carry, out_zero, out_overflow);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_wrap_pop out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_sub_overflow();
    bit   ok;
    exp_t e;
    int   w;
    out_ready = 1'b1;
    issue(2'b01, 32'h8000_0000, 32'h1, 5'd2, ok);
    w = 0;
    while (!out_valid && w < 5) begin @(negedge clk); w++; end
    checks++;
    if (!ok || !out_valid) begin errors++; $display("FAIL sub_ovf_timeout accepted=%b out_valid=%b required 1/1", ok, out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    $display("txn sub_ovf tag=%0d result=%h carry=%b ovf=%b", out_tag, out_result, out_carry, out_overflow);
    checks++;
    if (out_pack !== e) begin errors++; $display("FAIL sub_ovf_model got=%h required=%h", out_pack, e); end
    checks++;
    if (out_result !== 32'h7FFF_FFFF || out_carry !== 1'b1 || out_overflow !== 1'b1 || out_neg !== 1'b0) begin
      errors++;
      $display("FAIL sub_ovf_flags got r=%h c=%b v=%b n=%b required 7fffffff/1/1/0", out_result, out_carry, out_overflow, out_neg);
    end
    @(negedge clk);
  endtask

  task automatic test_carry_chain();
    bit          ok0, ok1;
    exp_t        e;
    int          n, w;
    logic [31:0] chain_exp;
`ifdef ADD_SUB_STAGE_CARRY_CHAIN_EN
    chain_exp = 32'h1;
`else
    chain_exp = 32'h0;
`endif
    out_ready = 1'b0;
    issue(2'b00, 32'hFFFF_FFFF, 32'h1, 5'd3, ok0);
    issue(2'b10, 32'h0, 32'h0, 5'd4, ok1);
    out_ready = 1'b1;
    n = 0; w = 0;
    while (n < 2 && w < 10) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        $display("txn chain tag=%0d result=%h carry=%b", out_tag, out_result, out_carry);
        checks++;
        if (out_pack !== e) begin errors++; $display("FAIL chain_model got=%h required=%h", out_pack, e); end
        if (n == 1) begin
          checks++;
          if (out_result !== chain_exp) begin
            errors++; $display("FAIL chain_addc got=%h required=%h", out_result, chain_exp);
          end
        end
        n++;
      end
      @(negedge clk); w++;
    end
    checks++;
    if (n != 2 || !ok0 || !ok1) begin errors++; $display("FAIL chain_count got=%0d required=2", n); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  rop [4];
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    exp_t        e;
    int          acc, w;
    bit          r;
    for (int k = 0; k < 4; k++) begin
      rop[k] = 2'($urandom_range(0, 3)); ra[k] = $urandom; rb[k] = $urandom;
    end
    out_ready = 1'b0; acc = 0;
    repeat (6) begin
      in_valid = (acc < 4);
      if (acc < 4) begin in_op = rop[acc]; in_a = ra[acc]; in_b = rb[acc]; in_tag = TAG_W'(8 + acc); end
      #1;
      r = in_valid && in_ready;
      @(posedge clk);
      if (r) begin push_expected(rop[acc], ra[acc], rb[acc], TAG_W'(8 + acc)); acc++; end
      @(negedge clk);
    end
    checks++;
    if (acc != 3) begin errors++; $display("FAIL stall_accepted got=%0d required=3", acc); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || out_pack !== exp_q[0]) begin
        errors++; $display("FAIL stall_stable cycle=%0d got=%h valid=%b", k, out_pack, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; w = 0;
    while ((acc < 4 || exp_q.size() > 0) && w < 20) begin
      in_valid = (acc < 4);
      if (acc < 4) begin in_op = rop[acc]; in_a = ra[acc]; in_b = rb[acc]; in_tag = TAG_W'(8 + acc); end
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL drain_unexpected got=%h required none", out_pack);
        end else begin
          e = exp_q.pop_front();
          $display("txn drain tag=%0d result=%h", out_tag, out_result);
          if (out_pack !== e) begin errors++; $display("FAIL drain_order got=%h required=%h", out_pack, e); end
        end
      end
      r = in_valid && in_ready;
      @(posedge clk);
      if (r) begin push_expected(rop[acc], ra[acc], rb[acc], TAG_W'(8 + acc)); acc++; end
      @(negedge clk); w++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL drain_done accepted=%0d pending=%0d required 4/0", acc, exp_q.size());
    end
  endtask

  task automatic test_random_stream();
    logic [1:0]  rop [N_RAND];
    logic [31:0] ra [N_RAND];
    logic [31:0] rb [N_RAND];
    exp_t        e;
    int          i, w, stalls, outs, first, last;
    bit          r;
    for (int k = 0; k < N_RAND; k++) begin
      rop[k] = 2'($urandom_range(0, 3));
      ra[k]  = (k % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      rb[k]  = (k % 5 == 0) ? 32'h0000_0001 : $urandom;
    end
    out_ready = 1'b1;
    i = 0; w = 0; stalls = 0; outs = 0; first = -1; last = -1;
    while ((i < N_RAND || exp_q.size() > 0) && w < N_RAND + 20) begin
      in_valid = (i < N_RAND);
      if (i < N_RAND) begin in_op = rop[i]; in_a = ra[i]; in_b = rb[i]; in_tag = TAG_W'(i); end
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected got=%h required none", out_pack);
        end else begin
          e = exp_q.pop_front();
          $display("txn rand tag=%0d result=%h", out_tag, out_result);
          if (out_pack !== e) begin errors++; $display("FAIL rand_model got=%h required=%h", out_pack, e); end
        end
        outs++;
        if (first < 0) first = w;
        last = w;
      end
      if (in_valid && !in_ready) stalls++;
      r = in_valid && in_ready;
      @(posedge clk);
      if (r) begin push_expected(rop[i], ra[i], rb[i], TAG_W'(i)); i++; end
      @(negedge clk); w++;
    end
    in_valid = 1'b0;
    checks++;
    if (outs != N_RAND) begin errors++; $display("FAIL rand_count got=%0d required=%0d", outs, N_RAND); end
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL rand_stalls got=%0d required=0", stalls); end
    checks++;
    if (last - first != N_RAND - 1) begin
      errors++; $display("FAIL rand_throughput span=%0d required=%0d", last - first, N_RAND - 1);
    end
  endtask

  task automatic test_reset_inflight();
    bit   ok0, ok1, ok2, ok3;
    exp_t e;
    int   w;
    out_ready = 1'b0;
    issue(2'b00, 32'hFFFF_FFFF, 32'h1, 5'd20, ok0);
    issue(2'b00, 32'hFFFF_FFFF, 32'h1, 5'd21, ok1);
    issue(2'b00, 32'h5, 32'h6, 5'd22, ok2);
    checks++;
    if (!(ok0 && ok1 && ok2) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL inflight_setup out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pack !== '0 || {add_a, add_b, add_cin} !== 65'd0) begin
      errors++; $display("FAIL inflight_reset out_valid=%b in_ready=%b out=%h", out_valid, in_ready, out_pack);
    end
    exp_q.delete();
    model_carry = 1'b0;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_stale cycle=%0d out=%h required none", k, out_pack); end
    end
    // ADDC 0+0 exposes whether the chained carry was cleared.
    issue(2'b10, 32'h0, 32'h0, 5'd23, ok3);
    w = 0;
    while (!out_valid && w < 5) begin @(negedge clk); w++; end
    checks++;
    if (!ok3 || !out_valid) begin errors++; $display("FAIL inflight_timeout out_valid=%b required 1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    $display("txn post_reset tag=%0d result=%h", out_tag, out_result);
    checks++;
    if (out_pack !== e || out_result !== 32'h0) begin
      errors++; $display("FAIL inflight_carry_cleared got=%h required=%h", out_pack, e);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_overflow();
    test_carry_chain();
    test_back_to_back();
    test_random_stream();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
